fxp_sum_accumulator: RTL

Streaming signed fixed-point accumulator with saturation, the parametrised successor to the plain two-operand adder. Each input beat carries `para_lanes` signed double-width fixed-point operands. The block sums them in a registered adder tree and accumulates beats until `in_last`. It then emits one saturated result through a valid/ready output. It sits between the multiplier array and the writeback path, reducing product vectors to dot-product results.

---
 rtl/fxp_pkg.sv | 39 +++
 rtl/lane_adder_tree.sv | 26 ++
 rtl/fxp_sum_accumulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: width derivation, the double-width Q type and
// a generic signed saturating clamp.
package fxp_pkg;

    // Widest value sat_clamp can handle; callers sign-extend into this.
    localparam int unsigned sat_max_w = 128;

    function automatic int unsigned calc_w(input int unsigned int_bits,
                                           input int unsigned frac_bits);
        return (int_bits + frac_bits) * 2;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned w,
                                            input int unsigned lanes,
                                            input int unsigned max_beats);
        return w + $clog2(lanes) + $clog2(max_beats);
    endfunction

    localparam int unsigned fxp_w = calc_w(7, 9);

    typedef logic signed [fxp_w-1:0] fxp2_t;

    // Returns {sat, result}; result is sign-extended to sat_max_w bits.
    function automatic logic [sat_max_w:0] sat_clamp(input logic signed [sat_max_w-1:0] value,
                                                     input int unsigned from_width,
                                                     input int unsigned to_width);
        logic signed [sat_max_w-1:0] one;
        logic signed [sat_max_w-1:0] hi;
        logic signed [sat_max_w-1:0] lo;
        one = 1;
        hi  = (one <<< (to_width - 1)) - one;
        lo  = -(one <<< (to_width - 1));
        if (to_width >= from_width) return {1'b0, value};
        if (value > hi) return {1'b1, hi};
        if (value < lo) return {1'b1, lo};
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational pairwise adder tree: lanes signed w-bit operands reduced to a
// single full-precision sum of w + clog2(lanes) bits.
module lane_adder_tree #(
    parameter int unsigned lanes = 4,
    parameter int unsigned w     = 32,
    localparam int unsigned lw   = $clog2(lanes),
    localparam int unsigned sw   = w + lw
) (
    input  logic [lanes*w-1:0] in_data,
    output logic [sw-1:0]      sum
);

    for (genvar l = 0; l <= lw; l++) begin : g_lvl
        logic signed [sw-1:0] s [lanes >> l];
        for (genvar k = 0; k < (lanes >> l); k++) begin : g_node
            if (l == 0) begin : g_leaf
                assign s[k] = sw'($signed(in_data[k*w +: w]));
            end else begin : g_add
                assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
            end
        end
    end

    assign sum = g_lvl[lw].s[0];

endmodule

// File: rtl/fxp_sum_accumulator.sv
// Streaming signed fixed-point group accumulator: registered lane sum, a
// saturating accumulator and a valid/ready result register.
module fxp_sum_accumulator
    import fxp_pkg::*;
#(
    parameter int unsigned para_int_bits  = 7,
    parameter int unsigned para_frac_bits = 9,
    parameter int unsigned para_lanes     = 4,
    parameter int unsigned para_max_beats = 256,
    localparam int unsigned w  = calc_w(para_int_bits, para_frac_bits),
    localparam int unsigned aw = calc_aw(w, para_lanes, para_max_beats)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [para_lanes*w-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [w-1:0]            out_data,
    output logic                    out_sat
);

    localparam int unsigned sw = w + $clog2(para_lanes);

    logic                 stall, accept, s2_go, load, pop;
    logic [sw-1:0]        lane_sum;
    logic signed [sw-1:0] s1_sum_q;
    logic                 s1_valid_q, s1_last_q;
    logic signed [aw-1:0] acc_q, acc_base, acc_next;
    logic signed [aw:0]   acc_wide;
    logic                 first_q, sticky_q;
    logic [sat_max_w:0]   aw_clamp, w_clamp;
    logic                 out_valid_q, out_sat_q;
    logic [w-1:0]         out_data_q;
    logic                 unused_clamp;

    lane_adder_tree #(
        .lanes (para_lanes),
        .w     (w)
    ) u_tree (
        .in_data (in_data),
        .sum     (lane_sum)
    );

    always_comb begin
        stall    = out_valid_q && !out_ready;
        accept   = in_valid && !stall;
        s2_go    = s1_valid_q && !stall;
        load     = s2_go && s1_last_q;
        pop      = out_valid_q && out_ready;
        acc_base = first_q ? '0 : acc_q;
        acc_wide = (aw + 1)'(acc_base) + (aw + 1)'(s1_sum_q);
        aw_clamp = sat_clamp(sat_max_w'(acc_wide), aw + 1, aw);
        acc_next = aw_clamp[aw-1:0];
        w_clamp  = sat_clamp(sat_max_w'(acc_next), aw, w);
    end

    assign unused_clamp = ^{aw_clamp[sat_max_w-1:aw], w_clamp[sat_max_w-1:w]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_q  <= $signed(lane_sum);
                s1_last_q <= in_last;
            end
        end
    end

    // Sticky remembers an accumulator overflow even if later beats pull the
    // sum back into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            first_q  <= 1'b1;
            sticky_q <= 1'b0;
        end else if (s2_go) begin
            if (s1_last_q) begin
                first_q  <= 1'b1;
                sticky_q <= 1'b0;
            end else begin
                acc_q    <= acc_next;
                first_q  <= 1'b0;
                sticky_q <= sticky_q | aw_clamp[sat_max_w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_clamp[w-1:0];
            out_sat_q   <= w_clamp[sat_max_w] | sticky_q | aw_clamp[sat_max_w];
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
